// File: rtl/pipe_run_ctrl.sv
// pipe_run_ctrl: run/step/halt sequencer gating pipeline advance; `PIPE_CYCLE_COUNTER_EN builds the cycle counter
module pipe_run_ctrl #(
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_WIDTH = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic cmd_valid,
    input  logic [1:0] cmd_op,
    output logic cmd_ready,
    output logic cmd_error,
    input  logic halt_in,
    output logic pipe_enable,
    output logic pc_hold,
    output logic pipe_clear,
    output logic halted,
    output logic busy,
    output logic [CNT_WIDTH-1:0] cycle_count
);
    typedef enum logic [2:0] {IDLE, RUN, STEP, DRAIN, HALTED} state_t;
    localparam logic [1:0] OP_RUN = 2'd0, OP_STEP = 2'd1, OP_STOP = 2'd2, OP_CLEAR = 2'd3;
    state_t state, state_nx;
    logic [3:0] drain_cnt, drain_nx;
    logic accept, err_nx, clr_nx;
    assign cmd_ready = !reset && (state == IDLE || state == RUN || state == HALTED);
    assign accept = cmd_valid && cmd_ready;
    // next state, drain counter and pulse requests; halt in RUN beats a simultaneous STOP
    always_comb begin
        state_nx = state;
        drain_nx = drain_cnt;
        err_nx = 1'b0;
        clr_nx = 1'b0;
        case (state)
            IDLE: if (accept) begin
                state_nx = cmd_op == OP_RUN ? RUN : cmd_op == OP_STEP ? STEP : IDLE;
                clr_nx = cmd_op == OP_CLEAR;
                err_nx = cmd_op == OP_STOP;
            end
            RUN: if (halt_in) begin
                state_nx = DRAIN;
                drain_nx = 4'(DRAIN_CYCLES);
                err_nx = accept && cmd_op != OP_STOP;
            end else if (accept) begin
                state_nx = cmd_op == OP_STOP ? IDLE : RUN;
                err_nx = cmd_op != OP_STOP;
            end
            STEP: begin
                state_nx = halt_in ? DRAIN : IDLE;
                drain_nx = halt_in ? 4'(DRAIN_CYCLES) : drain_cnt;
            end
            DRAIN: begin
                state_nx = drain_cnt <= 4'd1 ? HALTED : DRAIN;
                drain_nx = drain_cnt - 4'd1;
            end
            HALTED: if (accept) begin
                state_nx = cmd_op == OP_CLEAR ? IDLE : HALTED;
                clr_nx = cmd_op == OP_CLEAR;
                err_nx = cmd_op != OP_CLEAR;
            end
            default: state_nx = IDLE;
        endcase
    end
    // state register with outputs registered from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            drain_cnt <= '0;
            pipe_enable <= 1'b0;
            pc_hold <= 1'b0;
            halted <= 1'b0;
            busy <= 1'b0;
            cmd_error <= 1'b0;
            pipe_clear <= 1'b0;
        end else begin
            state <= state_nx;
            drain_cnt <= drain_nx;
            pipe_enable <= state_nx == RUN || state_nx == STEP || state_nx == DRAIN;
            pc_hold <= state_nx == DRAIN;
            halted <= state_nx == HALTED;
            busy <= state_nx == STEP || state_nx == DRAIN;
            cmd_error <= err_nx;
            pipe_clear <= clr_nx;
        end
    end
`ifdef PIPE_CYCLE_COUNTER_EN
    // count enabled cycles; CLEAR is only accepted while the pipe is stopped
    always_ff @(posedge clk) begin
        if (reset || clr_nx)
            cycle_count <= '0;
        else if (pipe_enable)
            cycle_count <= cycle_count + CNT_WIDTH'(1);
    end
`else
    assign cycle_count = '0;
`endif
endmodule

// File: doc/pipe_run_ctrl.md
# pipe_run_ctrl

Run/step/halt sequencer for the 5-stage MIPS pipeline. It sits between the debug command source and the core and gates pipeline advance with a single enable. It freezes fetch once a halt instruction is decoded and drains the in-flight instructions to writeback before reporting halted. It also counts executed cycles for the debug readout.

## Interface
Parameters:
- DRAIN_CYCLES, 4: cycles the pipeline keeps advancing with PC frozen after halt is decoded in ID. Covers EX, MEM, WB and register-file write. Legal range 1..15.
- CNT_WIDTH, 32: width of cycle_count.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_op  in  2  command: 00 RUN, 01 STEP, 10 STOP, 11 CLEAR.
- cmd_ready  out  1  controller can accept a command this cycle.
- cmd_error  out  1  one-cycle pulse: an accepted command was illegal in the current state.
- halt_in  in  1  halt opcode decoded in ID this cycle; qualified only when pipe_enable=1.
- pipe_enable  out  1  pipeline registers, PC and register file advance when high.
- pc_hold  out  1  PC frozen and IF/ID loaded with a bubble, even if pipe_enable=1.
- pipe_clear  out  1  one-cycle pulse that resets pipeline registers and PC to 0.
- halted  out  1  pipeline drained after halt.
- busy  out  1  state is STEP or DRAIN.
- cycle_count  out  CNT_WIDTH  cycles with pipe_enable=1 since the last reset or CLEAR.

## Operation
- Moore FSM with states IDLE, RUN, STEP, DRAIN, HALTED. All outputs decode from registered state, except the registered pulses cmd_error and pipe_clear.
- Command accept: cmd_valid & cmd_ready at a rising edge. cmd_ready is 1 in IDLE, RUN and HALTED, and 0 in STEP, DRAIN and while reset=1.
- IDLE: pipe_enable=0.
  - RUN → RUN.
  - STEP → STEP.
  - CLEAR → pulse pipe_clear, zero cycle_count, stay IDLE.
  - STOP → cmd_error, stay IDLE.
- RUN: pipe_enable=1.
  - halt_in → DRAIN; drain counter loads DRAIN_CYCLES.
  - STOP → IDLE.
  - RUN or STEP → cmd_error, stay RUN.
  - CLEAR → cmd_error.
- STEP: pipe_enable=1 for exactly one cycle.
  - halt_in → DRAIN.
  - Otherwise → IDLE.
- DRAIN: pipe_enable=1, pc_hold=1. The counter decrements each cycle; on reaching 1 → HALTED. halt_in is ignored.
- HALTED: pipe_enable=0, halted=1.
  - CLEAR → pulse pipe_clear, zero cycle_count, → IDLE.
  - RUN, STEP or STOP → cmd_error, stay HALTED.
- Simultaneous halt_in and accepted STOP in RUN: halt wins (→ DRAIN). STOP is dropped with no error.
- cycle_count increments on every edge where pipe_enable=1. It wraps from all-ones to 0 with no flag.

## Timing
- Reset:
  - state IDLE, drain counter 0, cycle_count 0.
  - pipe_enable, pc_hold, pipe_clear, halted, busy, cmd_error all 0.
  - cmd_ready 0 during reset, 1 from the first cycle after reset deasserts.
- Reset mid-operation (any state, including DRAIN) forces IDLE on the next edge. No drain completes and no pipe_clear pulse is generated.
- Command accepted at edge N → new state outputs valid from edge N to edge N+1.
- STEP yields exactly one pipe_enable cycle, then IDLE unless halt_in was high in that cycle.
- Halt latency: halt_in high in cycle k (state RUN):
  - cycle k keeps pipe_enable=1 and pc_hold=0;
  - cycles k+1..k+DRAIN_CYCLES are DRAIN;
  - halted=1 from cycle k+DRAIN_CYCLES+1.
- pipe_clear and cmd_error are high for exactly the cycle after the accepting edge.

## Configuration
- PIPE_CYCLE_COUNTER_EN defined: cycle_count register and incrementer present as described.
- Not defined: no counter logic; cycle_count is tied to 0. All FSM behaviour is unchanged.

## Test plan
- Reset then RUN; hold halt_in=0 for 20 cycles → pipe_enable=1 for all 20, cycle_count=20, cmd_ready=1.
- RUN; halt_in pulse at cycle 10, DRAIN_CYCLES=4 → pc_hold=1 cycles 11–14; halted=1 from cycle 15; cycle_count=14; pipe_enable=0 afterwards.
- Three STEP commands, 3 cycles apart, from IDLE → exactly 3 pipe_enable pulses of 1 cycle each; cmd_ready=0 during each STEP cycle; cycle_count=3.
- In HALTED: RUN → cmd_error pulse, still halted. Then CLEAR → pipe_clear pulse, cycle_count=0, state IDLE, halted=0.
- RUN with STOP and halt_in in the same cycle → DRAIN entered, no cmd_error. Then assert reset in the 2nd DRAIN cycle → next cycle IDLE, all outputs at reset values, halted never set.
- With PIPE_CYCLE_COUNTER_EN undefined, rerun the halt scenario → identical FSM outputs and cycle_count=0 throughout.
